// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel gradient stage for a raster stream of grey pixels.
//   Two internal line buffers supply the upper rows of the window. One
//   saturated gradient magnitude is emitted per interior pixel, tagged with
//   the window-centre coordinates, three clocks after the accepting cycle.
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active-low
//   gs_in       grey pixel (DATA_W)
//   gs_valid    gs_in/x_in/y_in valid this cycle
//   x_in, y_in  column/row of gs_in (11 bits)
//   mode        00 |Gx|, 01 |Gy|, 1x |Gx|+|Gy|; latched on the (0,0) accept
//   thresh      binarise level (only with SOBEL_THRESH_EN)
//   edge_out    saturated magnitude, held between pulses
//   edge_valid  single-cycle result strobe
//   x_out,y_out window-centre coordinates, held between pulses
//
// Build option: define SOBEL_THRESH_EN to binarise the magnitude against
// thresh (thresh is latched together with mode on the (0,0) accept).
module sobel_edge #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 1280,
  parameter int IMG_H  = 960
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] gs_in,
  input  logic              gs_valid,
  input  logic [10:0]       x_in,
  input  logic [10:0]       y_in,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] thresh,
  output logic [DATA_W-1:0] edge_out,
  output logic              edge_valid,
  output logic [10:0]       x_out,
  output logic [10:0]       y_out
);

  localparam int unsigned AW   = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int unsigned LW_U = LINE_W;
  localparam int          GW   = DATA_W + 3;
  localparam int          MW   = DATA_W + 4;
  localparam logic [DATA_W-1:0] SAT = '1;

  // ---------------------------------------------------------------- accept
  logic          w_accept;
  logic          w_origin;
  logic          w_interior;
  logic [AW-1:0] w_addr;

  assign w_accept   = gs_valid && (32'(x_in) < LW_U);
  assign w_origin   = w_accept && (x_in == '0) && (y_in == '0);
  assign w_interior = w_accept && (x_in >= 11'd2) && (y_in >= 11'd2);
  assign w_addr     = x_in[AW-1:0];

  // ---------------------------------------------------------- line buffers
  logic [DATA_W-1:0] r_lb0 [LINE_W];
  logic [DATA_W-1:0] r_lb1 [LINE_W];
  logic [DATA_W-1:0] w_lb0;
  logic [DATA_W-1:0] w_lb1;

  assign w_lb0 = r_lb0[w_addr];
  assign w_lb1 = r_lb1[w_addr];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[w_addr] <= w_lb0;
      r_lb0[w_addr] <= gs_in;
    end
  end

  // ---------------------------------------------------------- S1: window
  // r_win[row][col]; row 0 = two lines up, col 2 = newest column.
  logic [DATA_W-1:0] r_win [3][3];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int unsigned r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb1;
      r_win[1][2] <= w_lb0;
      r_win[2][2] <= gs_in;
    end
  end

  // ------------------------------------------------------- S2: gradients
  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;

  assign w_gx = (ext(r_win[0][2]) + (ext(r_win[1][2]) <<< 1) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + (ext(r_win[1][0]) <<< 1) + ext(r_win[2][0]));
  assign w_gy = (ext(r_win[2][0]) + (ext(r_win[2][1]) <<< 1) + ext(r_win[2][2]))
              - (ext(r_win[0][0]) + (ext(r_win[0][1]) <<< 1) + ext(r_win[0][2]));

  // ------------------------------------------------------- S3: magnitude
  logic signed [GW-1:0] r_gx;
  logic signed [GW-1:0] r_gy;
  logic [1:0]           r_m2;
  logic [GW-1:0]        w_ax;
  logic [GW-1:0]        w_ay;
  logic [MW-1:0]        w_sum;
  logic [DATA_W-1:0]    w_sat;
  logic [DATA_W-1:0]    w_res;

  assign w_ax = r_gx[GW-1] ? -r_gx : r_gx;
  assign w_ay = r_gy[GW-1] ? -r_gy : r_gy;

  always_comb begin
    w_sum = '0;
    case (r_m2)
      2'b00:   w_sum = MW'(w_ax);
      2'b01:   w_sum = MW'(w_ay);
      default: w_sum = MW'(w_ax) + MW'(w_ay);
    endcase
  end

  assign w_sat = (w_sum > MW'(SAT)) ? SAT : w_sum[DATA_W-1:0];

  // Mode (and threshold) ride along the pipeline with each pixel, so a new
  // frame's (0,0) accept cannot alter results still in flight.
  logic       r_armed;
  logic [1:0] r_mode;
  logic [1:0] r_m1;
  logic [1:0] w_mode_cur;

  assign w_mode_cur = w_origin ? mode : r_mode;

`ifdef SOBEL_THRESH_EN
  logic [DATA_W-1:0] r_thresh;
  logic [DATA_W-1:0] r_t1;
  logic [DATA_W-1:0] r_t2;

  assign w_res = (w_sat >= r_t2) ? SAT : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_thresh <= '0;
      r_t1     <= '0;
      r_t2     <= '0;
    end else begin
      if (w_origin) r_thresh <= thresh;
      if (w_accept) r_t1     <= w_origin ? thresh : r_thresh;
      r_t2 <= r_t1;
    end
  end

  logic w_unused;
  assign w_unused = ^{32'(IMG_H)};
`else
  assign w_res = w_sat;

  logic w_unused;
  assign w_unused = ^{thresh, 32'(IMG_H)};
`endif

  // ------------------------------------------------------ control/pipeline
  logic        r_v1;
  logic        r_v2;
  logic [10:0] r_x1;
  logic [10:0] r_y1;
  logic [10:0] r_x2;
  logic [10:0] r_y2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed    <= 1'b0;
      r_mode     <= '0;
      r_v1       <= 1'b0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_m1       <= '0;
      r_v2       <= 1'b0;
      r_x2       <= '0;
      r_y2       <= '0;
      r_m2       <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      edge_valid <= 1'b0;
      edge_out   <= '0;
      x_out      <= '0;
      y_out      <= '0;
    end else begin
      if (w_origin) begin
        r_armed <= 1'b1;
        r_mode  <= mode;
      end
      // (0,0) is never interior, so the registered armed flag suffices here.
      r_v1 <= w_interior && r_armed;
      if (w_accept) begin
        r_x1 <= x_in - 11'd1;
        r_y1 <= y_in - 11'd1;
        r_m1 <= w_mode_cur;
      end
      r_v2 <= r_v1;
      r_x2 <= r_x1;
      r_y2 <= r_y1;
      r_m2 <= r_m1;
      r_gx <= w_gx;
      r_gy <= w_gy;
      edge_valid <= r_v2;
      if (r_v2) begin
        edge_out <= w_res;
        x_out    <= r_x2;
        y_out    <= r_y2;
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: randomized/directed bench for sobel_edge (LINE_W=8, IMG_H=6).
//   A frame-image reference model computes each expected magnitude directly
//   from the pixels it has seen and schedules it three clocks after the
//   accepting cycle; a negedge monitor compares every cycle.
module tb_sobel_edge;

  localparam int DW = 12;
  localparam int LW = 8;
  localparam int IH = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] gs_in;
  logic          gs_valid;
  logic [10:0]   x_in;
  logic [10:0]   y_in;
  logic [1:0]    mode;
  logic [DW-1:0] thresh;
  logic [DW-1:0] edge_out;
  logic          edge_valid;
  logic [10:0]   x_out;
  logic [10:0]   y_out;

  sobel_edge #(.DATA_W(DW), .LINE_W(LW), .IMG_H(IH)) dut (
    .clk        (clk),
    .rst        (rst),
    .gs_in      (gs_in),
    .gs_valid   (gs_valid),
    .x_in       (x_in),
    .y_in       (y_in),
    .mode       (mode),
    .thresh     (thresh),
    .edge_out   (edge_out),
    .edge_valid (edge_valid),
    .x_out      (x_out),
    .y_out      (y_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------- model
  typedef struct {
    int unsigned due;
    int          val;
    int          x;
    int          y;
  } exp_t;

  exp_t q[$];
  int   m_img [IH][LW];
  bit   m_armed = 1'b0;
  int   m_mode  = 0;
  int   m_thr   = 0;
  int   m_nexp  = 0;
  int   pulses  = 0;

  function automatic int ref_mag(input int r, input int c, input int md, input int th);
    int p [3][3];
    int gx, gy, ax, ay, m;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[i][j] = m_img[r-2+i][c-2+j];
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (md == 0)      m = ax;
    else if (md == 1) m = ay;
    else              m = ax + ay;
    if (m > 4095) m = 4095;
`ifdef SOBEL_THRESH_EN
    m = (m >= th) ? 4095 : 0;
`else
    if (th > 4095) m = 0;
`endif
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int x, input int y, input int pix);
    exp_t e;
    gs_valid = v;
    x_in     = 11'(x);
    y_in     = 11'(y);
    gs_in    = DW'(pix);
    if (v && x < LW) begin
      if (x == 0 && y == 0) begin
        m_armed = 1'b1;
        m_mode  = int'(mode);
        m_thr   = int'(thresh);
      end
      m_img[y][x] = pix;
      if (m_armed && x >= 2 && y >= 2) begin
        e.due = cyc + 3;
        e.val = ref_mag(y, x, m_mode, m_thr);
        e.x   = x - 1;
        e.y   = y - 1;
        q.push_back(e);
        m_nexp++;
      end
    end
    tick();
  endtask

  task automatic do_reset();
    gs_valid = 1'b0;
    rst      = 1'b0;
    q.delete();
    m_armed  = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(edge_valid), 0);
    check("rst_edge",  32'(edge_out),   0);
    check("rst_x",     32'(x_out),      0);
    check("rst_y",     32'(y_out),      0);
    rst    = 1'b1;
    pulses = 0;
    m_nexp = 0;
  endtask

  // kind: 0 flat 0x800, 1 step 0/0x100, 2 step 0/0xFFF, 3 random
  // gaps: 0 none, 1 valid pattern 1,0,0, 2 random rejected cycles
  task automatic run_frame(input int kind, input int gaps, input int rst_row, input int mid_mode);
    int pix;
    pulses = 0;
    m_nexp = 0;
    for (int y = 0; y < IH; y++) begin
      for (int x = 0; x < LW; x++) begin
        if (y == rst_row && x == 0) do_reset();
        if (mid_mode >= 0 && y == 3 && x == 0) mode = 2'(mid_mode);
        case (kind)
          0:       pix = 'h800;
          1:       pix = (x >= 4) ? 'h100 : 0;
          2:       pix = (x >= 4) ? 'hFFF : 0;
          default: pix = int'($urandom_range(0, 4095));
        endcase
        drive(1'b1, x, y, pix);
        if (gaps == 1) begin
          drive(1'b0, x, y, pix ^ 1);
          drive(1'b0, x, y, 0);
        end else if (gaps == 2 && $urandom_range(0, 2) == 0) begin
          drive(1'($urandom_range(0, 1)), LW + int'($urandom_range(0, 30)), y,
                int'($urandom_range(0, 4095)));
        end
      end
    end
    repeat (6) drive(1'b0, 0, 0, 0);
    check("npulse", 32'(pulses), 32'(m_nexp));
  endtask

  // ----------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        check("valid", 32'(edge_valid), 1);
        check("edge",  32'(edge_out),   32'(q[0].val));
        check("x_out", 32'(x_out),      32'(q[0].x));
        check("y_out", 32'(y_out),      32'(q[0].y));
        void'(q.pop_front());
      end else begin
        check("idle_valid", 32'(edge_valid), 0);
      end
      if (edge_valid === 1'b1) pulses++;
    end
  end

  // ----------------------------------------------------------- stimulus
  initial begin
    rst      = 1'b0;
    gs_valid = 1'b0;
    gs_in    = '0;
    x_in     = '0;
    y_in     = '0;
    mode     = 2'b00;
    thresh   = '0;
    tick();
    tick();
    check("reset_valid", 32'(edge_valid), 0);
    check("reset_edge",  32'(edge_out),   0);
    check("reset_x",     32'(x_out),      0);
    check("reset_y",     32'(y_out),      0);
    rst = 1'b1;
    tick();

    // flat frame
    mode = 2'b00; run_frame(0, 0, -1, -1);
    check("flat_count", 32'(pulses), 24);

    // vertical step, each mode
    mode = 2'b00; run_frame(1, 0, -1, -1);
    mode = 2'b01; run_frame(1, 0, -1, -1);
    mode = 2'b10; run_frame(1, 0, -1, -1);

    // saturating step; mid-frame mode change applies next frame only
    mode = 2'b10; run_frame(2, 0, -1, 1);
    run_frame(2, 0, -1, -1);

    // sparse valid pattern
    mode = 2'b00; run_frame(1, 1, -1, -1);

    // reset mid-frame, then a clean frame
    run_frame(0, 0, 3, -1);
    check("post_rst_pulses", 32'(pulses), 0);
    run_frame(0, 0, -1, -1);
    check("after_rst_count", 32'(pulses), 24);

`ifdef SOBEL_THRESH_EN
    mode = 2'b00; thresh = 'h200; run_frame(1, 0, -1, -1);
    thresh = 'h500; run_frame(1, 0, -1, -1);
`endif

    // random frames, random mode/threshold, rejected cycles interleaved
    for (int f = 0; f < 5; f++) begin
      mode   = 2'($urandom_range(0, 3));
      thresh = DW'($urandom_range(0, 4095));
      run_frame(3, (f % 2 == 0) ? 2 : 1, -1, -1);
    end

    check("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
